// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Gates writes on FIFO full and keeps write / stall statistics.
module fifo_wr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N-1:0]                        req_valid,
    input  logic [N*DW-1:0]                     req_data,
    output logic [N-1:0]                        req_ready,
    input  logic [2:0]                          fifo_status,
    output logic [DW-1:0]                       write_data,
    output logic                                wr_en,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id,
    output logic                                stall,
    output logic [31:0]                         wr_count,
    output logic [15:0]                         stall_count
);

    localparam int ID_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [2:0] STATUS_FULL = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_FULL
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;

    logic            fifo_full;
    logic            any_req;
    logic            found;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] next_ptr;
    logic [N-1:0]    grant_onehot;

    assign fifo_full = (fifo_status == STATUS_FULL);
    assign any_req   = |req_valid;

    // Scan requesters starting at rr_ptr, wrapping modulo N.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        found        = 1'b0;
        grant        = '0;
        next_ptr     = '0;
        grant_onehot = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
        if (int'(grant) + 1 < N) next_ptr = ID_W'(int'(grant) + 1);
        grant_onehot[grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset
    // branch clears every register, so no output powers up undefined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            req_ready   <= '0;
            write_data  <= '0;
            wr_en       <= 1'b0;
            grant_id    <= '0;
            stall       <= 1'b0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            req_ready <= '0;
            wr_en     <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req && fifo_full) begin
                        state <= WAIT_FULL;
                        stall <= 1'b1;
                    end else if (any_req && found) begin
                        write_data <= req_data[grant*DW +: DW];
                        req_ready  <= grant_onehot;
                        wr_en      <= 1'b1;
                        grant_id   <= grant;
                        rr_ptr     <= next_ptr;
                        wr_count   <= wr_count + 32'd1;
                        state      <= WRITE;
                    end
                end
                // FIFO count settles during WRITE; IDLE then sees fresh status.
                WRITE: state <= IDLE;
                WAIT_FULL: begin
                    if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
                    if (!fifo_full || !any_req) begin
                        state <= IDLE;
                        stall <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
